// File: rtl/calc_pkg.sv
// Shared types and constants for the BCD calculator core.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } calc_state_e;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

endpackage

// File: rtl/bcd_digit_addsub.sv
// One-digit BCD adder/subtractor: mode 0 adds with carry, mode 1 subtracts with borrow.
module bcd_digit_addsub
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             cin,
  input  logic             mode,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  logic [BCD_W:0] sum;
  logic [BCD_W:0] diff;

  always_comb begin
    sum   = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
    diff  = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, cin};
    digit = '0;
    cout  = 1'b0;
    if (!mode) begin
      if (sum > (BCD_W + 1)'(BCD_MAX)) begin
        digit = BCD_W'(sum - (BCD_W + 1)'(10));
        cout  = 1'b1;
      end else begin
        digit = sum[BCD_W-1:0];
      end
    end else begin
      // MSB set means the 5-bit difference wrapped below zero
      if (diff[BCD_W]) begin
        digit = BCD_W'(diff + (BCD_W + 1)'(10));
        cout  = 1'b1;
      end else begin
        digit = diff[BCD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bcd_calc_core.sv
// Two-operand BCD calculator: button-driven operand counters, digit-serial add/subtract.
module bcd_calc_core
  import calc_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          Button1,
  input  logic                          Button2,
  input  logic                          Operation,
  input  logic                          Equals,
  output logic [BCD_W*DIGITS-1:0]       NumberA,
  output logic [BCD_W*DIGITS-1:0]       NumberB,
  output logic [BCD_W*(DIGITS+1)-1:0]   Result,
  output logic                          Neg,
  output logic                          Busy,
  output logic                          Done
);

  localparam int W     = BCD_W * DIGITS;
  localparam int RW    = BCD_W * (DIGITS + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  calc_state_e      state_q, state_d;
  logic [W-1:0]     numa_q, numa_d, numb_q, numb_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [RW-1:0]    result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_q, op_d, carry_q, carry_d, neg_q, neg_d;
  logic             b1_prev_q, b2_prev_q, eq_prev_q;
  logic             b1_edge, b2_edge, eq_edge;
  logic [BCD_W-1:0] dig_x, dig_y, dig_out;
  logic             dig_cout;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[i*BCD_W +: BCD_W] == BCD_W'(BCD_MAX)) begin
          r[i*BCD_W +: BCD_W] = '0;
        end else begin
          r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + BCD_W'(1);
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign b1_edge = Button1 & ~b1_prev_q;
  assign b2_edge = Button2 & ~b2_prev_q;
  assign eq_edge = Equals  & ~eq_prev_q;

  assign dig_x = opa_q[idx_q*BCD_W +: BCD_W];
  assign dig_y = opb_q[idx_q*BCD_W +: BCD_W];

  bcd_digit_addsub u_digit (
    .x     (dig_x),
    .y     (dig_y),
    .cin   (carry_q),
    .mode  (op_q),
    .digit (dig_out),
    .cout  (dig_cout)
  );

  always_comb begin
    state_d  = state_q;
    numa_d   = numa_q;
    numb_d   = numb_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    op_d     = op_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (eq_edge) begin
          // Subtract always runs larger-minus-smaller; sign is carried in Neg
          op_d    = Operation;
          neg_d   = Operation && (numa_q < numb_q);
          opa_d   = (Operation && (numa_q < numb_q)) ? numb_q : numa_q;
          opb_d   = (Operation && (numa_q < numb_q)) ? numa_q : numb_q;
          acc_d   = '0;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ST_CALC;
        end else begin
          if (b1_edge) numa_d = bcd_inc(numa_q);
          if (b2_edge) numb_d = bcd_inc(numb_q);
          if ((b1_edge || b2_edge) && state_q == ST_DONE) state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d[idx_q*BCD_W +: BCD_W] = dig_out;
        carry_d = dig_cout;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          result_d = {{(BCD_W-1){1'b0}}, dig_cout & ~op_q, acc_d};
          idx_d    = '0;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      numa_q    <= '0;
      numb_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      op_q      <= 1'b0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      b1_prev_q <= 1'b0;
      b2_prev_q <= 1'b0;
      eq_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      numa_q    <= numa_d;
      numb_q    <= numb_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      neg_q     <= neg_d;
      b1_prev_q <= Button1;
      b2_prev_q <= Button2;
      eq_prev_q <= Equals;
    end
  end

  assign NumberA = numa_q;
  assign NumberB = numb_q;
  assign Result  = result_q;
  assign Neg     = neg_q;
  assign Busy    = (state_q == ST_CALC);
  assign Done    = (state_q == ST_DONE);

endmodule

// File: doc/bcd_calc_core.md
BCD_CALC_CORE -- requirements
Module: bcd_calc_core

Interface
REQ-001 SHALL have parameter DIGITS, default 2, meaning BCD digits per operand (1..8).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port Button1  in  1  increment operand A, level input, rising edge detected internally.
REQ-005 SHALL have port Button2  in  1  increment operand B, level input, rising edge detected internally.
REQ-006 SHALL have port Operation  in  1  0 = add, 1 = subtract; sampled only at start.
REQ-007 SHALL have port Equals  in  1  start compute on rising edge.
REQ-008 SHALL have port NumberA  out  4*DIGITS  operand A, packed BCD, digit 0 in LSBs.
REQ-009 SHALL have port NumberB  out  4*DIGITS  operand B, packed BCD.
REQ-010 SHALL have port Result  out  4*(DIGITS+1)  magnitude of result, packed BCD.
REQ-011 SHALL have port Neg  out  1  result is negative.
REQ-012 SHALL have port Busy  out  1  high while in CALC.
REQ-013 SHALL have port Done  out  1  high while in DONE.

Function
REQ-014 Edge detect SHALL use one previous-value register per button; edge = input & ~prev.
REQ-015 An edge on Button1 or Button2 SHALL increment NumberA or NumberB by 1 decimal, with carry across digits; 10^DIGITS-1 SHALL wrap to 0.
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-017 In IDLE or DONE, an Equals edge SHALL latch Operation and both operands, then enter CALC the next cycle.
REQ-018 An Equals edge SHALL take priority over any button edge in the same cycle; that button edge SHALL be dropped.
REQ-019 At start, for subtract with A<B (unsigned packed-BCD compare), operands SHALL be swapped and Neg set to 1; otherwise Neg SHALL be 0.
REQ-020 CALC SHALL process one digit per cycle, LSB digit first, for exactly DIGITS cycles, using a digit index counter.
REQ-021 Add digit rule: s = x+y+c; if s>9 then digit = s-10 and c = 1, else digit = s and c = 0.
REQ-022 Subtract digit rule: d = x-y-b; if d<0 then digit = d+10 and b = 1, else digit = d and b = 0.
REQ-023 After the last digit, Result top digit SHALL be the final carry for add, or 0 for subtract; the FSM SHALL then enter DONE.
REQ-024 Latency: Equals edge sampled at cycle n gives Busy high for cycles n+1..n+DIGITS and Done high from cycle n+DIGITS+1.
REQ-025 During CALC, Button1, Button2, Equals and Operation edges SHALL be ignored; prev registers SHALL still update.
REQ-026 In DONE, a button edge SHALL apply its increment and return to IDLE; Result and Neg SHALL hold until the next compute.
REQ-027 Result SHALL update only on completion of CALC; partial digits SHALL be kept in an internal accumulator.

Reset
REQ-028 Reset SHALL clear NumberA, NumberB, Result, Neg, Busy, Done, the accumulator, the digit index and the prev registers, and set state to IDLE.
REQ-029 Reset SHALL override all other inputs, including mid-CALC; the aborted compute SHALL leave no residue.
REQ-030 After reset, a button already held high SHALL count as one edge on the first cycle after Reset deasserts.

Structure
REQ-031 Package calc_pkg SHALL hold the FSM state enum, BCD_W = 4 and BCD_MAX = 9.
REQ-032 Sub-module bcd_digit_addsub SHALL be combinational, with ports x, y, carry/borrow-in and mode, producing digit and carry/borrow-out; the core SHALL instantiate it once.

Verification (DIGITS=2)
REQ-033 Scenario: 7 Button1 edges, 5 Button2 edges, Operation=0, Equals -> Busy for 2 cycles, then Done, Result=012, Neg=0.
REQ-034 Scenario: A=03, B=08, Operation=1, Equals -> Result=005, Neg=1; repeat with A=08, B=03 -> Result=005, Neg=0.
REQ-035 Scenario: A=99, B=99, add -> Result=198; then 1 Button1 edge -> NumberA=00, state IDLE, Result still 198.
REQ-036 Scenario: Reset asserted on the second CALC cycle -> next cycle all outputs 0, state IDLE.
REQ-037 Scenario: Equals and Button1 edges in the same IDLE cycle with A=04, B=02, add -> Result=006, NumberA stays 04.
REQ-038 Scenario: Button2 toggled and Operation flipped during CALC -> NumberB unchanged and result uses the operation latched at start.
